// File: rtl/dispatch_steer_pkg.sv
// Shared types and sizing for the dispatch steering block and its producer table.
package dispatch_steer_pkg;

    localparam int NUM_FUS    = 4;
    localparam int RS_ENTRIES = 8;
    localparam int NUM_PREGS  = 64;
    localparam int NUM_SLOTS  = RS_ENTRIES * NUM_FUS;
    localparam int PREG_W     = $clog2(NUM_PREGS);
    localparam int SLOT_W     = $clog2(NUM_SLOTS);
    localparam int ENTRY_W    = $clog2(RS_ENTRIES);
    localparam int FU_W       = $clog2(NUM_FUS);

    typedef struct packed {
        logic              valid;
        logic [SLOT_W-1:0] slot;
    } producer_entry_t;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [PREG_W-1:0] dst_preg;
        logic [PREG_W-1:0] src1_preg;
        logic [PREG_W-1:0] src2_preg;
    } disp_packet_t;

    function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
        slot_onehot    = '0;
        slot_onehot[s] = 1'b1;
    endfunction

endpackage

// File: rtl/dispatch_steer_producer_table.sv
// Preg-to-producer-slot table: two lookup ports, one write port, wakeup clear and flush.
module dispatch_steer_producer_table
    import dispatch_steer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [PREG_W-1:0]    src1,
    input  logic [PREG_W-1:0]    src2,
    input  logic [NUM_SLOTS-1:0] ready_mask,
    input  logic                 wr_en,
    input  logic [PREG_W-1:0]    wr_preg,
    input  logic [SLOT_W-1:0]    wr_slot,
    output logic [NUM_SLOTS-1:0] dep1,
    output logic [NUM_SLOTS-1:0] dep2
);

    producer_entry_t table_q [NUM_PREGS];

    // A same-cycle write beats the wakeup clear; flush beats both.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PREGS; i++) begin
            if (!rst || flush) begin
                table_q[i] <= '0;
            end else if (wr_en && wr_preg == PREG_W'(i)) begin
                table_q[i] <= '{valid: 1'b1, slot: wr_slot};
            end else if (table_q[i].valid && ready_mask[table_q[i].slot]) begin
                table_q[i].valid <= 1'b0;
            end
        end
    end

    always_comb begin
        dep1 = '0;
        dep2 = '0;
        if (src1 != '0 && table_q[src1].valid && !ready_mask[table_q[src1].slot])
            dep1 = slot_onehot(table_q[src1].slot);
        if (src2 != '0 && table_q[src2].valid && !ready_mask[table_q[src2].slot])
            dep2 = slot_onehot(table_q[src2].slot);
    end

endmodule

// File: rtl/dispatch_steer.sv
// Round-robin steering of renamed instructions to FU schedulers with dependency-mask build.
// Optional DISP_STEER_STATS_EN adds saturating dispatch/stall counters.
module dispatch_steer
    import dispatch_steer_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  disp_packet_t                 in_pkt,
    input  logic                         in_has_dst,
    input  logic [NUM_FUS-1:0]           in_fu_mask,
    input  logic [NUM_FUS-1:0]           rs_full,
    input  logic [NUM_FUS*ENTRY_W-1:0]   rs_entry_idx,
    input  logic [NUM_SLOTS-1:0]         global_ready_mask,
    input  logic                         flush,
    output logic [NUM_FUS-1:0]           disp_valid,
    output disp_packet_t                 disp_pkt,
    output logic [NUM_SLOTS-1:0]         dependency_mask
`ifdef DISP_STEER_STATS_EN
    ,
    output logic [31:0]                  stat_dispatched,
    output logic [31:0]                  stat_stall
`endif
);

    logic                 out_valid;
    logic [FU_W-1:0]      out_fu;
    logic                 out_has_dst;
    logic [FU_W-1:0]      rr;

    logic [ENTRY_W-1:0]   entry_of [NUM_FUS];
    logic [NUM_FUS-1:0]   elig;
    logic [FU_W-1:0]      sel;
    logic [FU_W-1:0]      idx;
    logic                 found;
    logic                 handshake;
    logic                 wr_en;
    logic [SLOT_W-1:0]    out_slot;
    logic                 byp1;
    logic                 byp2;
    logic [NUM_SLOTS-1:0] dep1;
    logic [NUM_SLOTS-1:0] dep2;
    logic [NUM_SLOTS-1:0] dep;

    for (genvar k = 0; k < NUM_FUS; k++) begin : g_fu
        assign entry_of[k] = rs_entry_idx[k*ENTRY_W +: ENTRY_W];
        assign elig[k]     = in_fu_mask[k] && !rs_full[k] && !(out_valid && out_fu == FU_W'(k));
    end

    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int o = 0; o < NUM_FUS; o++) begin
            idx = rr + FU_W'(o);
            if (!found && elig[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    assign in_ready  = rst && !flush && found;
    assign handshake = in_valid && in_ready;

    // The OUT-stage instruction is the producer being written into the table this cycle.
    assign out_slot = {out_fu, entry_of[out_fu]};
    assign wr_en    = out_valid && out_has_dst && disp_pkt.dst_preg != '0;
    assign byp1     = wr_en && disp_pkt.dst_preg == in_pkt.src1_preg;
    assign byp2     = wr_en && disp_pkt.dst_preg == in_pkt.src2_preg;
    assign dep      = (byp1 ? slot_onehot(out_slot) : dep1) | (byp2 ? slot_onehot(out_slot) : dep2);

    dispatch_steer_producer_table u_table (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .src1       (in_pkt.src1_preg),
        .src2       (in_pkt.src2_preg),
        .ready_mask (global_ready_mask),
        .wr_en      (wr_en),
        .wr_preg    (disp_pkt.dst_preg),
        .wr_slot    (out_slot),
        .dep1       (dep1),
        .dep2       (dep2)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid       <= 1'b0;
            out_fu          <= '0;
            out_has_dst     <= 1'b0;
            rr              <= '0;
            disp_pkt        <= '0;
            dependency_mask <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (handshake) begin
            out_valid       <= 1'b1;
            out_fu          <= sel;
            out_has_dst     <= in_has_dst;
            rr              <= sel + 1'b1;
            disp_pkt        <= in_pkt;
            dependency_mask <= dep;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Gated by rst so a mid-operation reset never emits a strobe.
    always_comb begin
        disp_valid = '0;
        if (out_valid && rst)
            disp_valid[out_fu] = 1'b1;
    end

`ifdef DISP_STEER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_dispatched <= '0;
            stat_stall      <= '0;
        end else begin
            if (handshake && stat_dispatched != '1)
                stat_dispatched <= stat_dispatched + 32'd1;
            if (in_valid && !in_ready && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_steer.sv
// Directed self-checking bench for dispatch_steer (stats checked when DISP_STEER_STATS_EN is set).
module tb_dispatch_steer;
    import dispatch_steer_pkg::*;

    logic                       clk;
    logic                       rst;
    logic                       in_valid;
    logic                       in_ready;
    disp_packet_t               in_pkt;
    logic                       in_has_dst;
    logic [NUM_FUS-1:0]         in_fu_mask;
    logic [NUM_FUS-1:0]         rs_full;
    logic [NUM_FUS*ENTRY_W-1:0] rs_entry_idx;
    logic [NUM_SLOTS-1:0]       global_ready_mask;
    logic                       flush;
    logic [NUM_FUS-1:0]         disp_valid;
    disp_packet_t               disp_pkt;
    logic [NUM_SLOTS-1:0]       dependency_mask;
`ifdef DISP_STEER_STATS_EN
    logic [31:0]                stat_dispatched;
    logic [31:0]                stat_stall;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    dispatch_steer dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pkt            (in_pkt),
        .in_has_dst        (in_has_dst),
        .in_fu_mask        (in_fu_mask),
        .rs_full           (rs_full),
        .rs_entry_idx      (rs_entry_idx),
        .global_ready_mask (global_ready_mask),
        .flush             (flush),
        .disp_valid        (disp_valid),
        .disp_pkt          (disp_pkt),
        .dependency_mask   (dependency_mask)
`ifdef DISP_STEER_STATS_EN
        ,
        .stat_dispatched   (stat_dispatched),
        .stat_stall        (stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int dst, input int s1, input int s2, input logic [NUM_FUS-1:0] m);
        in_valid           = v;
        in_pkt.opcode      = 8'h11;
        in_pkt.dst_preg    = PREG_W'(dst);
        in_pkt.src1_preg   = PREG_W'(s1);
        in_pkt.src2_preg   = PREG_W'(s2);
        in_has_dst         = (dst != 0);
        in_fu_mask         = m;
        #1;
    endtask

    initial begin
        rst               = 1'b0;
        flush             = 1'b0;
        rs_full           = '0;
        global_ready_mask = '0;
        // FU3..FU0 next free entries: 7, 1, 5, 2
        rs_entry_idx      = {3'd7, 3'd1, 3'd5, 3'd2};
        drive(1'b1, 10, 20, 30, 4'b0001);

        // reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_disp_valid", disp_valid, 0);
        check("rst_dep_mask", dependency_mask, 0);
        check("rst_disp_pkt", disp_pkt, 0);

        // first instruction, single FU
        rst = 1'b1;
        #1;
        check("t1_in_ready", in_ready, 1);
        tick();
        drive(1'b0, 0, 0, 0, 4'b0000);
        check("t1_disp_valid", disp_valid, 4'b0001);
        check("t1_dep_mask", dependency_mask, 0);
        check("t1_dst", disp_pkt.dst_preg, 10);
        check("t1_fu_mask0_not_ready", in_ready, 0);
        tick();
        check("t1_one_cycle", disp_valid, 0);

        // producer then back-to-back dependent via OUT bypass
        drive(1'b1, 5, 0, 0, 4'b0001);
        tick();
        check("t2_prod_valid", disp_valid, 4'b0001);
        drive(1'b1, 11, 5, 0, 4'b0001);
        check("t2_no_back_to_back", in_ready, 0);
        drive(1'b1, 11, 5, 0, 4'b0011);
        check("t2_ready", in_ready, 1);
        tick();
        drive(1'b0, 0, 0, 0, 4'b0000);
        check("t2_disp_valid", disp_valid, 4'b0010);
        check("t2_dep_bypass", dependency_mask, 32'h0000_0004);

        // wakeup bypass and clear
        tick();
        tick();
        tick();
        global_ready_mask = 32'h0000_0004;
        drive(1'b1, 12, 5, 10, 4'b0001);
        tick();
        global_ready_mask = '0;
        drive(1'b0, 0, 0, 0, 4'b0000);
        check("t3_disp_valid", disp_valid, 4'b0001);
        check("t3_dep_woken", dependency_mask, 0);
        tick();
        drive(1'b1, 0, 5, 11, 4'b0100);
        tick();
        drive(1'b0, 0, 0, 0, 4'b0000);
        check("t3_disp_valid2", disp_valid, 4'b0100);
        check("t3_dep_after_clear", dependency_mask, 32'h0000_2000);
        tick();

        // all schedulers full
        rs_full = 4'b1111;
        drive(1'b1, 1, 0, 0, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            check("t4_full_ready", in_ready, 0);
            tick();
            check("t4_full_no_disp", disp_valid, 0);
        end
        rs_full = '0;
        drive(1'b0, 0, 0, 0, 4'b0000);
`ifdef DISP_STEER_STATS_EN
        check("t4_stat_stall", stat_stall, 5);
        check("t4_stat_dispatched", stat_dispatched, 5);
`endif

        // flush clears the table
        drive(1'b1, 7, 0, 0, 4'b0010);
        tick();
        drive(1'b0, 0, 0, 0, 4'b0000);
        check("t6_prod_valid", disp_valid, 4'b0010);
        tick();
        flush = 1'b1;
        drive(1'b1, 0, 7, 0, 4'b0001);
        check("t6_flush_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        #1;
        check("t6_after_flush_valid", disp_valid, 0);
        check("t6_ready_again", in_ready, 1);
        tick();
        drive(1'b0, 0, 0, 0, 4'b0000);
        check("t6_disp_valid", disp_valid, 4'b0001);
        check("t6_dep_after_flush", dependency_mask, 0);

        // flush wins over a same-cycle table write
        drive(1'b1, 9, 0, 0, 4'b0100);
        tick();
        flush = 1'b1;
        drive(1'b0, 0, 0, 0, 4'b0000);
        tick();
        flush = 1'b0;
        drive(1'b1, 0, 9, 0, 4'b0100);
        tick();
        drive(1'b0, 0, 0, 0, 4'b0000);
        check("t6_flush_vs_write", dependency_mask, 0);

        // mid-operation reset suppresses the strobe
        rst = 1'b0;
        #1;
        check("t7_midreset_strobe", disp_valid, 0);
        tick();
        tick();
        rst = 1'b1;

        // round-robin across all FUs from reset
        for (int i = 0; i < NUM_FUS; i++) begin
            drive(1'b1, 0, 0, 0, 4'b1111);
            check("t5_rr_ready", in_ready, 1);
            tick();
            check("t5_rr_disp_valid", disp_valid, 4'b0001 << i);
        end
        drive(1'b0, 0, 0, 0, 4'b0000);
        tick();
        check("t5_idle", disp_valid, 0);
`ifdef DISP_STEER_STATS_EN
        check("t5_stat_dispatched", stat_dispatched, 4);
        check("t5_stat_stall", stat_stall, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
